alu_arbiter: RTL and testbench

Two-port arbiter that shares one 32-bit integer ALU between two requesters, e.g. the main execute stage and a multi-cycle helper unit such as an address generator or mul/div sequencer. Each port has a valid/ready request channel and a private one-entry response buffer with its own valid/ready handshake. When both ports are eligible in the same cycle, a round-robin pointer decides which one wins. Results are registered, so latency is one cycle from request acceptance to response valid.

---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu.sv | 33 +++
 rtl/alu_arbiter.sv | 99 +++++++++
 tb/tb_alu_arbiter.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the two-port ALU arbiter: datapath width, opcode
// encoding and the opcode legality check.
package alu_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [3:0] {
        OP_ADD  = 4'b0000,
        OP_SLL  = 4'b0001,
        OP_SLT  = 4'b0010,
        OP_SLTU = 4'b0011,
        OP_XOR  = 4'b0100,
        OP_SRL  = 4'b0101,
        OP_OR   = 4'b0110,
        OP_AND  = 4'b0111,
        OP_SUB  = 4'b1000,
        OP_SRA  = 4'b1101
    } alu_op_e;

    // True for the ten defined opcodes; every other code is reported as err.
    function automatic logic is_legal_op(input logic [3:0] op);
        case (op)
            OP_ADD, OP_SLL, OP_SLT, OP_SLTU, OP_XOR,
            OP_SRL, OP_OR, OP_AND, OP_SUB, OP_SRA: return 1'b1;
            default:                               return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu.sv
// Purely combinational 32-bit integer ALU. The shift amount arrives already
// masked to five bits so the shifter never sees the upper bits of b.
module alu
    import alu_pkg::*;
(
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [4:0]        shamt,
    output logic [DATA_W-1:0] result,
    output logic              err
);

    // Opcode decode; illegal codes yield zero data with err set.
    always_comb begin
        result = '0;
        err    = !is_legal_op(op);
        case (op)
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_SLL:  result = a << shamt;
            OP_SLT:  result = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: result = {{(DATA_W-1){1'b0}}, (a < b)};
            OP_XOR:  result = a ^ b;
            OP_SRL:  result = a >> shamt;
            OP_SRA:  result = $unsigned($signed(a) >>> shamt);
            OP_OR:   result = a | b;
            OP_AND:  result = a & b;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Two requesters share one ALU. Handshake rule for every channel: a transfer
// happens on a rising edge where valid and ready are both high; the producer
// holds its payload while valid is high and ready is low. Request ready is
// a combinational function of request valid, so a requester must never derive
// its valid from ready. Contention is resolved round-robin on last_grant.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int TAG_W = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         flush_i,
    input  logic [1:0]                   req_valid_i,
    output logic [1:0]                   req_ready_o,
    input  logic [1:0][3:0]              req_op_i,
    input  logic [1:0][DATA_W-1:0]       req_a_i,
    input  logic [1:0][DATA_W-1:0]       req_b_i,
    input  logic [1:0][TAG_W-1:0]        req_tag_i,
    output logic [1:0]                   rsp_valid_o,
    input  logic [1:0]                   rsp_ready_i,
    output logic [1:0][DATA_W-1:0]       rsp_data_o,
    output logic [1:0][TAG_W-1:0]        rsp_tag_o,
    output logic [1:0]                   rsp_err_o
);

    logic              last_grant;
    logic [1:0]        elig;
    logic [1:0]        grant;
    logic              sel;
    logic [3:0]        op_m;
    logic [DATA_W-1:0] a_m;
    logic [DATA_W-1:0] b_m;
    logic [TAG_W-1:0]  tag_m;
    logic [DATA_W-1:0] alu_res;
    logic              alu_err;

    // A port may be granted when it has a request and its buffer is empty or
    // draining this edge; reset and flush suppress all grants.
    always_comb begin
        elig = '0;
        for (int r = 0; r < 2; r++) begin
            elig[r] = req_valid_i[r] && (!rsp_valid_o[r] || rsp_ready_i[r])
                      && !flush_i && !rst_i;
        end
    end

    // Round-robin pick: on contention the port that did not win last time wins.
    always_comb begin
        grant = elig;
        if (elig == 2'b11) begin
            grant = last_grant ? 2'b01 : 2'b10;
        end
    end

    assign req_ready_o = grant;
    assign sel         = grant[1];
    assign op_m        = req_op_i[sel];
    assign a_m         = req_a_i[sel];
    assign b_m         = req_b_i[sel];
    assign tag_m       = req_tag_i[sel];

    alu u_alu (
        .op     (op_m),
        .a      (a_m),
        .b      (b_m),
        .shamt  (b_m[4:0]),
        .result (alu_res),
        .err    (alu_err)
    );

    // Round-robin pointer and the two one-entry response buffers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_grant  <= 1'b1;
            rsp_valid_o <= '0;
            rsp_data_o  <= '0;
            rsp_tag_o   <= '0;
            rsp_err_o   <= '0;
        end else begin
            if (|grant) begin
                last_grant <= grant[1];
            end
            for (int r = 0; r < 2; r++) begin
                if (flush_i) begin
                    rsp_valid_o[r] <= 1'b0;
                end else if (grant[r]) begin
                    rsp_valid_o[r] <= 1'b1;
                    rsp_data_o[r]  <= alu_res;
                    rsp_tag_o[r]   <= tag_m;
                    rsp_err_o[r]   <= alu_err;
                end else if (rsp_ready_i[r]) begin
                    rsp_valid_o[r] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a reference ALU, a small handshake model
// and a per-port queue of expected responses ({err, tag, data}).
module tb_alu_arbiter;

    localparam int TAG_W = 4;
    localparam int RW    = 1 + TAG_W + 32;

    logic                   clk;
    logic                   rst;
    logic                   flush;
    logic [1:0]             req_valid;
    logic [1:0]             req_ready;
    logic [1:0][3:0]        req_op;
    logic [1:0][31:0]       req_a;
    logic [1:0][31:0]       req_b;
    logic [1:0][TAG_W-1:0]  req_tag;
    logic [1:0]             rsp_valid;
    logic [1:0]             rsp_ready;
    logic [1:0][31:0]       rsp_data;
    logic [1:0][TAG_W-1:0]  rsp_tag;
    logic [1:0]             rsp_err;

    logic [RW-1:0] exp_q[2][$];
    logic [1:0]    m_valid;
    logic          m_last;
    int            checks;
    int            errors;

    alu_arbiter #(.TAG_W(TAG_W)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .flush_i     (flush),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_op_i    (req_op),
        .req_a_i     (req_a),
        .req_b_i     (req_b),
        .req_tag_i   (req_tag),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_data_o  (rsp_data),
        .rsp_tag_o   (rsp_tag),
        .rsp_err_o   (rsp_err)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // Reference ALU: returns {err, data}.
    function automatic logic [32:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        case (op)
            4'b0000: return {1'b0, a + b};
            4'b1000: return {1'b0, a - b};
            4'b0001: return {1'b0, a << b[4:0]};
            4'b0010: return {1'b0, 31'd0, ($signed(a) < $signed(b))};
            4'b0011: return {1'b0, 31'd0, (a < b)};
            4'b0100: return {1'b0, a ^ b};
            4'b0101: return {1'b0, a >> b[4:0]};
            4'b1101: return {1'b0, $unsigned($signed(a) >>> b[4:0])};
            4'b0110: return {1'b0, a | b};
            4'b0111: return {1'b0, a & b};
            default: return {1'b1, 32'd0};
        endcase
    endfunction

    // One clock cycle: check grant and buffered responses against the model,
    // update the model and scoreboard, then advance past the rising edge.
    task automatic step();
        logic [1:0]    elig;
        logic [1:0]    g;
        logic [32:0]   r;
        logic [RW-1:0] e;
        #1;
        for (int p = 0; p < 2; p++) begin
            elig[p] = req_valid[p] && (!m_valid[p] || rsp_ready[p]) && !flush && !rst;
        end
        g = elig;
        if (elig == 2'b11) g = m_last ? 2'b01 : 2'b10;
        chk("req_ready", {62'd0, req_ready}, {62'd0, g});
        chk("rsp_valid", {62'd0, rsp_valid}, {62'd0, m_valid});
        for (int p = 0; p < 2; p++) begin
            if (m_valid[p]) begin
                if (exp_q[p].size() == 0) begin
                    chk("queue_empty", 64'd1, 64'd0);
                end else begin
                    e = exp_q[p][0];
                    chk("rsp_data", {32'd0, rsp_data[p]}, {32'd0, e[31:0]});
                    chk("rsp_tag", {60'd0, rsp_tag[p]}, {60'd0, e[35:32]});
                    chk("rsp_err", {63'd0, rsp_err[p]}, {63'd0, e[36]});
                end
            end
        end
        for (int p = 0; p < 2; p++) begin
            if (rst || flush) begin
                exp_q[p].delete();
                m_valid[p] = 1'b0;
            end else begin
                if (m_valid[p] && rsp_ready[p] && exp_q[p].size() > 0) void'(exp_q[p].pop_front());
                if (g[p]) begin
                    r = ref_alu(req_op[p], req_a[p], req_b[p]);
                    exp_q[p].push_back({r[32], req_tag[p], r[31:0]});
                    m_valid[p] = 1'b1;
                end else if (rsp_ready[p]) begin
                    m_valid[p] = 1'b0;
                end
            end
        end
        if (rst) m_last = 1'b1;
        else if (|g) m_last = g[1];
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int p, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [TAG_W-1:0] tag);
        req_op[p]  = op;
        req_a[p]   = a;
        req_b[p]   = b;
        req_tag[p] = tag;
    endtask

    logic [3:0] legal_ops [10];
    logic       pre_last;

    initial begin
        checks = 0;
        errors = 0;
        legal_ops = '{4'h0, 4'h8, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'hD, 4'h6, 4'h7};
        m_valid = 2'b00;
        m_last  = 1'b1;
        rst = 1'b1; flush = 1'b0; req_valid = 2'b00; rsp_ready = 2'b00;
        req_op = '0; req_a = '0; req_b = '0; req_tag = '0;
        @(posedge clk);
        #1;
        step();

        // Reset values
        chk("rst_valid", {62'd0, rsp_valid}, 64'd0);
        chk("rst_data", rsp_data, 64'd0);
        chk("rst_tag", {56'd0, rsp_tag}, 64'd0);
        chk("rst_err", {62'd0, rsp_err}, 64'd0);
        chk("rst_ready", {62'd0, req_ready}, 64'd0);
        rst = 1'b0;

        // Single ADD on port 0
        rsp_ready = 2'b11;
        drive(0, 4'h0, 32'd7, 32'd5, 4'd3);
        req_valid = 2'b01;
        step();
        req_valid = 2'b00;
        chk("add_data", {32'd0, rsp_data[0]}, 64'd12);
        chk("add_tag", {60'd0, rsp_tag[0]}, 64'd3);
        step();

        // Round-robin contention
        drive(0, 4'h8, 32'd5, 32'd7, 4'd1);
        drive(1, 4'hD, 32'h8000_0000, 32'd4, 4'd2);
        req_valid = 2'b11;
        step();
        chk("sra_data", {32'd0, rsp_data[1]}, 64'hF800_0000);
        step();
        chk("sub_data", {32'd0, rsp_data[0]}, 64'hFFFF_FFFE);
        for (int i = 0; i < 6; i++) begin
            for (int p = 0; p < 2; p++) begin
                drive(p, legal_ops[$urandom_range(0, 9)], $urandom, $urandom, 4'($urandom_range(0, 15)));
            end
            step();
        end

        // Back-pressure on port 0
        rsp_ready = 2'b10;
        step();
        step();
        for (int i = 0; i < 4; i++) begin
            drive(1, 4'h4, $urandom, $urandom, 4'(i));
            #1;
            chk("bp_ready", {62'd0, req_ready}, 64'd2);
            step();
        end
        rsp_ready = 2'b11;
        drive(0, 4'h0, 32'h1234_0000, 32'h0000_5678, 4'd9);
        #1;
        chk("bp_reload_ready", {62'd0, req_ready}, 64'd1);
        step();
        chk("bp_reload_data", {32'd0, rsp_data[0]}, 64'h1234_5678);
        req_valid = 2'b00;
        step();

        // Illegal opcode on port 1, then a legal SLTU
        drive(1, 4'hF, 32'd3, 32'd4, 4'd5);
        req_valid = 2'b10;
        step();
        chk("ill_err", {63'd0, rsp_err[1]}, 64'd1);
        chk("ill_data", {32'd0, rsp_data[1]}, 64'd0);
        drive(1, 4'h3, 32'd1, 32'hFFFF_FFFF, 4'd6);
        step();
        chk("sltu_err", {63'd0, rsp_err[1]}, 64'd0);
        chk("sltu_data", {32'd0, rsp_data[1]}, 64'd1);
        req_valid = 2'b00;
        step();

        // Flush with both ports valid and both buffers full
        rsp_ready = 2'b00;
        req_valid = 2'b11;
        step();
        step();
        step();
        pre_last = m_last;
        flush = 1'b1;
        #1;
        chk("flush_ready", {62'd0, req_ready}, 64'd0);
        step();
        flush = 1'b0;
        chk("flush_valid", {62'd0, rsp_valid}, 64'd0);
        rsp_ready = 2'b11;
        #1;
        chk("flush_last", {62'd0, req_ready}, pre_last ? 64'd1 : 64'd2);
        step();
        step();

        // Reset mid-operation
        rsp_ready = 2'b00;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        req_valid = 2'b00;
        chk("mid_rst_valid", {62'd0, rsp_valid}, 64'd0);
        chk("mid_rst_data", rsp_data, 64'd0);
        chk("mid_rst_tag", {56'd0, rsp_tag}, 64'd0);
        chk("mid_rst_err", {62'd0, rsp_err}, 64'd0);
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        #1;
        chk("post_rst_winner", {62'd0, req_ready}, 64'd1);
        step();
        step();
        req_valid = 2'b00;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
